// File: rtl/mem_responder_if.sv
// mem_responder_if: per-channel valid/ready read/write request bus.
interface mem_responder_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_CHANNELS  = 4
);
  logic [NUM_CHANNELS-1:0]                    mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                    mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_read_data;
  logic [NUM_CHANNELS-1:0]                    mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_write_data;
  logic [NUM_CHANNELS-1:0]                    mem_write_ready;
  modport master (
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );
  modport slave (
    input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: multi-channel memory responder, round-robin onto one single-port RAM.
module mem_responder #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int LATENCY       = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output logic            busy
);
  localparam int NC = NUM_CHANNELS;
  localparam int PW = NC > 1 ? $clog2(NC) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, PENDING, DELAY, RESPOND, DRAIN} state_t;
  state_t state_q [NC];
  state_t state_d [NC];
  logic [NC-1:0]                    op_q, op_d;
  logic [NC-1:0][ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [NC-1:0][DATA_WIDTH-1:0]    wdata_q, wdata_d, rdata_q, rdata_d, word_q;
  logic [NC-1:0][CW-1:0]            cnt_q, cnt_d;
  logic [NC-1:0]                    rrdy_q, rrdy_d, wrdy_q, wrdy_d, wr_req;
  logic [PW-1:0]                    rr_ptr, gnt_idx, j;
  logic                             gnt_any;
  logic [DATA_WIDTH-1:0]            ram [2**ADDRESS_WIDTH];
  assign wr_req = WRITE_ENABLE != 0 ? bus.mem_write_valid : '0;
  assign bus.mem_read_ready  = rrdy_q;
  assign bus.mem_write_ready = WRITE_ENABLE != 0 ? wrdy_q : '0;
  assign bus.mem_read_data   = rdata_q;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j = '0;
    for (int k = 0; k < NC; k++) begin
      j = PW'((int'(rr_ptr) + k) % NC);
      if (!gnt_any && state_q[j] == PENDING) begin
        gnt_any = 1'b1;
        gnt_idx = j;
      end
    end
  end
  // op: 1 = write; read wins when both valids are raised together
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      addr_d[i]  = addr_q[i];
      wdata_d[i] = wdata_q[i];
      cnt_d[i]   = cnt_q[i];
      rrdy_d[i]  = 1'b0;
      wrdy_d[i]  = 1'b0;
      rdata_d[i] = rdata_q[i];
      case (state_q[i])
        IDLE:
          if (bus.mem_read_valid[i]) begin
            state_d[i] = PENDING;
            op_d[i]    = 1'b0;
            addr_d[i]  = bus.mem_read_address[i];
          end else if (wr_req[i]) begin
            state_d[i] = PENDING;
            op_d[i]    = 1'b1;
            addr_d[i]  = bus.mem_write_address[i];
            wdata_d[i] = bus.mem_write_data[i];
          end
        PENDING:
          if (gnt_any && gnt_idx == PW'(i)) begin
            state_d[i] = DELAY;
            cnt_d[i]   = CW'(LATENCY - 1);
          end
        DELAY:
          if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
          else begin
            state_d[i] = RESPOND;
            rrdy_d[i]  = !op_q[i];
            wrdy_d[i]  = op_q[i];
            rdata_d[i] = op_q[i] ? rdata_q[i] : word_q[i];
          end
        RESPOND: state_d[i] = DRAIN;
        DRAIN:   if (!bus.mem_read_valid[i] && !wr_req[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) state_q[i] <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rrdy_q  <= '0;
      wrdy_q  <= '0;
      rdata_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rrdy_q  <= rrdy_d;
      wrdy_q  <= wrdy_d;
      rdata_q <= rdata_d;
      if (gnt_any) rr_ptr <= gnt_idx == PW'(NC - 1) ? '0 : gnt_idx + 1'b1;
    end
  end
  // RAM array and per-channel read latches are deliberately outside reset
  always_ff @(posedge clk)
    if (gnt_any) word_q[gnt_idx] <= ram[addr_q[gnt_idx]];
  if (WRITE_ENABLE != 0) begin : g_write
    always_ff @(posedge clk)
      if (gnt_any && op_q[gnt_idx]) ram[addr_q[gnt_idx]] <= wdata_q[gnt_idx];
  end
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NC; i++) busy = busy | (state_q[i] != IDLE);
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench; channels 0-3 on the writable instance, 4-7 on the read-only one.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy_a, busy_b;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct { bit wr; logic [15:0] data; int cyc; } exp_t;
  exp_t q [8][$];
  logic [7:0] hold = '0;

  mem_responder_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_CHANNELS(4)) ia ();
  mem_responder_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_CHANNELS(4)) ib ();

  mem_responder #(.WRITE_ENABLE(1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave), .busy(busy_a));
  mem_responder #(.WRITE_ENABLE(0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < 8; c++) n += q[c].size();
    return n;
  endfunction

  function automatic logic [15:0] rd(input int c);
    return c < 4 ? ia.mem_read_data[2'(c)] : ib.mem_read_data[2'(c)];
  endfunction

  task automatic drop(input int c);
    if (c < 4) begin
      ia.mem_read_valid[2'(c)] = 1'b0;
      ia.mem_write_valid[2'(c)] = 1'b0;
    end else begin
      ib.mem_read_valid[2'(c)] = 1'b0;
      ib.mem_write_valid[2'(c)] = 1'b0;
    end
  endtask

  // lat: cycles from the drive point to the negedge where ready must be seen
  task automatic req(input int c, input bit wr, input logic [7:0] addr, input logic [15:0] data,
                     input logic [15:0] ed, input int lat);
    exp_t e;
    e.wr = wr;
    e.data = ed;
    e.cyc = cyc + lat;
    q[c].push_back(e);
    if (c < 4) begin
      if (wr) begin
        ia.mem_write_valid[2'(c)] = 1'b1;
        ia.mem_write_address[2'(c)] = addr;
        ia.mem_write_data[2'(c)] = data;
      end else begin
        ia.mem_read_valid[2'(c)] = 1'b1;
        ia.mem_read_address[2'(c)] = addr;
      end
    end else begin
      if (wr) begin
        ib.mem_write_valid[2'(c)] = 1'b1;
        ib.mem_write_address[2'(c)] = addr;
        ib.mem_write_data[2'(c)] = data;
      end else begin
        ib.mem_read_valid[2'(c)] = 1'b1;
        ib.mem_read_address[2'(c)] = addr;
      end
    end
  endtask

  task automatic tick();
    logic [7:0] rr, wr;
    exp_t e;
    @(negedge clk);
    rr = {ib.mem_read_ready, ia.mem_read_ready};
    wr = {ib.mem_write_ready, ia.mem_write_ready};
    check("excl_a", ia.mem_read_ready & ia.mem_write_ready, 0);
    check("excl_b", ib.mem_read_ready & ib.mem_write_ready, 0);
    for (int c = 0; c < 8; c++) begin
      if (rr[c] || wr[c]) begin
        if (q[c].size() == 0) check($sformatf("unexpected_ready_ch%0d", c), {rr[c], wr[c]}, 0);
        else begin
          e = q[c].pop_front();
          check($sformatf("kind_ch%0d", c), wr[c], e.wr);
          check($sformatf("cycle_ch%0d", c), cyc, e.cyc);
          if (!e.wr) check($sformatf("rdata_ch%0d", c), rd(c), e.data);
          if (!hold[c]) drop(c);
        end
      end
    end
  endtask

  task automatic run();
    int left = 40;
    while (pending() != 0 && left > 0) begin
      tick();
      left--;
    end
    check("responses_drained", pending(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    ia.mem_read_valid = '0; ia.mem_read_address = '0; ia.mem_write_valid = '0;
    ia.mem_write_address = '0; ia.mem_write_data = '0;
    ib.mem_read_valid = '0; ib.mem_read_address = '0; ib.mem_write_valid = '0;
    ib.mem_write_address = '0; ib.mem_write_data = '0;
    idle(2);
    check("rst_rready", ia.mem_read_ready, 0);
    check("rst_wready", ia.mem_write_ready, 0);
    check("rst_rdata", ia.mem_read_data, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    dut_b.ram[8'h33] = 16'hA5A5;
    idle(1);
    // write then read back on ch0; rr_ptr ends at 1
    req(0, 1, 8'h10, 16'hBEEF, 16'h0, 4);
    run(); idle(3);
    check("busy_after_write", busy_a, 0);
    req(0, 0, 8'h10, 16'h0, 16'hBEEF, 4);
    run(); idle(3);
    // ch1..3 writes from rr_ptr=1 leave rr_ptr at 0
    req(1, 1, 8'h41, 16'h4141, 16'h0, 4);
    req(2, 1, 8'h42, 16'h4242, 16'h0, 5);
    req(3, 1, 8'h43, 16'h4343, 16'h0, 6);
    run(); idle(3);
    // all four read together from rr_ptr=0
    req(0, 0, 8'h10, 16'h0, 16'hBEEF, 4);
    req(1, 0, 8'h41, 16'h0, 16'h4141, 5);
    req(2, 0, 8'h42, 16'h0, 16'h4242, 6);
    req(3, 0, 8'h43, 16'h0, 16'h4343, 7);
    run(); idle(3);
    // same-address write/read race, rr_ptr=0: write first
    req(1, 1, 8'h22, 16'h1234, 16'h0, 4);
    req(2, 0, 8'h22, 16'h0, 16'h1234, 5);
    run(); idle(3);
    req(1, 0, 8'h22, 16'h0, 16'h1234, 4);
    run(); idle(3);
    // rr_ptr=2: read wins and sees the prior value
    req(2, 0, 8'h22, 16'h0, 16'h1234, 4);
    req(1, 1, 8'h22, 16'h5678, 16'h0, 5);
    run(); idle(3);
    req(0, 0, 8'h22, 16'h0, 16'h5678, 4);
    run(); idle(3);
    // held valid: single pulse, stays busy until dropped
    hold[0] = 1'b1;
    req(0, 0, 8'h41, 16'h0, 16'h4141, 4);
    run(); idle(4);
    check("hold_busy", busy_a, 1);
    check("hold_rdata", ia.mem_read_data[0], 16'h4141);
    hold[0] = 1'b0;
    drop(0);
    tick();
    check("drop_idle", busy_a, 0);
    req(0, 0, 8'h42, 16'h0, 16'h4242, 4);
    run(); idle(3);
    // reset during DELAY drops the request
    req(0, 0, 8'h10, 16'h0, 16'hBEEF, 4);
    idle(2);
    reset = 1'b1;
    drop(0);
    q[0].delete();
    #1;
    check("mid_rst_rready", ia.mem_read_ready, 0);
    check("mid_rst_rdata", ia.mem_read_data, 0);
    check("mid_rst_busy", busy_a, 0);
    tick();
    reset = 1'b0;
    idle(6);
    check("post_rst_busy", busy_a, 0);
    req(0, 0, 8'h10, 16'h0, 16'hBEEF, 4);
    run(); idle(3);
    // read-only instance ignores writes
    ib.mem_write_valid[0] = 1'b1;
    ib.mem_write_address[0] = 8'h33;
    ib.mem_write_data[0] = 16'hFFFF;
    repeat (6) begin
      tick();
      check("ro_busy", busy_b, 0);
    end
    drop(4);
    req(4, 0, 8'h33, 16'h0, 16'hA5A5, 4);
    run(); idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
